dff_delay_line: RTL
===================

# dff_delay_line

Parametrised, runtime-programmable delay line. It is the generalised successor of the fixed 4-stage single-bit D flip-flop chain: configurable data width and maximum depth, per-stage valid tracking, clock enable, synchronous flush, and an occupancy counter. It sits on datapath alignment points, for example to match a data stream against a slower control path of known latency.

## Interface
Parameters:
- WIDTH, 8, data bits per stage (≥1)
- DEPTH, 16, maximum number of stages (≥1)
- Derived localparam DW = clog2(DEPTH+1), width of the delay and count fields

Ports:
- CLK  in  1  clock, rising-edge
- RST  in  1  reset, asynchronous, active-high
- i_en  in  1  shift enable; when low, all state holds
- i_flush  in  1  synchronous flush: clears all stage valid bits and the count
- i_cfg_we  in  1  load new delay from i_delay
- i_delay  in  DW  requested delay, in stages
- i_valid  in  1  input sample valid
- i_data  in  WIDTH  input sample
- o_valid  out  1  valid bit of the tapped stage
- o_data  out  WIDTH  tapped data; forced to 0 when o_valid=0
- o_delay  out  DW  active delay D
- o_count  out  DW  number of valid samples currently in stages 0..D-1

## Operation
- Storage: DEPTH stages, each holding {valid, data}. Stage 0 takes the input. The tap is stage D-1.
- Delay load on i_cfg_we: D ← clamp(i_delay), where 0→1 and values >DEPTH→DEPTH.
  - The same edge clears all valid bits and the count.
  - The sample on i_valid in that cycle is dropped.
- Flush: clears all valid bits and o_count. Data registers are not cleared. The sample on i_valid in that cycle is dropped.
- Shift (i_en=1, no flush, no cfg write): every stage takes its predecessor and stage 0 takes {i_valid, i_data}.
  - o_count ← o_count + i_valid − o_valid, using the o_valid value before the edge.
  - Samples shifted beyond stage D-1 are discarded, whether or not they are valid.
- Hold (i_en=0): no state changes. o_* remain stable.
- Priority: RST > i_flush > i_cfg_we > i_en. When flush and cfg_we occur together, the delay is still loaded.
- Arithmetic rules:
  - o_count stays within 0..D, with no wrap.
  - Increment and decrement on the same edge cancel.
  - Any counter over/underflow is a design bug. The bench checks for it with an assertion.

## Timing
- Reset values:
  - all valid bits 0, data 0
  - o_valid=0, o_data=0
  - o_delay=DEPTH, o_count=0
- Latency: a sample captured at enabled edge k appears on o_valid/o_data after the D-th enabled edge, counting k as the first. Disabled cycles do not count.
- o_* are driven from registers through the tap mux only. There is no combinational path from i_* to o_*.
- Configuration effects are visible one cycle after their edge:
  - o_delay updates on the edge after i_cfg_we.
  - The flush effect appears after its edge.
- Asserting RST mid-stream clears everything immediately. Deasserting RST must meet the normal recovery time, with no output glitches.
- Throughput: one sample per enabled cycle, with no bubbles inserted.

## Structure
- Shared package dff_pkg:
  - clog2 function
  - clamp_delay function
  - a stage struct typedef {valid, data[WIDTH]}
- Sub-module dff_stage: a single {valid, data} register with async RST, enable, and synchronous valid-clear. It is instantiated DEPTH times through a generate loop.
- The top level holds the delay register, the count register, and the tap mux.

## Test plan
- Reset, then WIDTH=8, DEPTH=16, delay 4 with i_en=1. Drive values 0x01..0x0A with valid. Required: 0x01 appears on o_data 4 cycles later with o_valid=1, the sequence is in order, and o_count settles at 4.
- i_en toggled 1,0,0,1… while streaming at delay 3. Required: output advances only on enabled edges, o_data is held stable while disabled, and no sample is lost or duplicated.
- i_flush asserted while 5 samples are in flight. Required: o_valid=0 and o_count=0 on the next cycle; the sample offered during the flush cycle never emerges; a new sample emerges after D cycles.
- Writes of i_delay=0, then 20, then 7. Required: o_delay reads 1, 16 and 7 respectively; valid bits are cleared on each write; the delay-1 path shows a 1-cycle latency.
- RST asserted mid-stream at delay 16 with the line full. Required: all outputs reset asynchronously, without waiting for a clock edge. After release, the first new sample emerges 16 enabled cycles later.
- Random valid/enable/flush stimulus over 10k cycles, checked against a scoreboard queue model. Required: o_count always equals the model occupancy and never exceeds D.

Source files
------------

// File: rtl/dff_pkg.sv
// Shared types and helper functions for the programmable delay line.
package dff_pkg;

  localparam int unsigned DefWidth = 8;

  // Reference stage layout at the default data width; modules declare a WIDTH-sized twin.
  typedef struct packed {
    logic                valid;
    logic [DefWidth-1:0] data;
  } stage_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) result++;
    return result;
  endfunction

  // A zero delay still costs one register; anything past the last stage saturates.
  function automatic int unsigned clamp_delay(input int unsigned req, input int unsigned depth);
    if (req == 0) return 1;
    if (req > depth) return depth;
    return req;
  endfunction

endpackage

// File: rtl/dff_stage.sv
// One {valid, data} register of the delay line with enable and synchronous valid-clear.
module dff_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // Clearing drops only the valid flag; stale data stays masked at the tap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (en_i) begin
      valid_q <= valid_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/dff_delay_line.sv
// Runtime-programmable delay line: DEPTH stages, tap at stage D-1, occupancy counter.
module dff_delay_line
  import dff_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned DW = clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_en,
  input  logic             i_flush,
  input  logic             i_cfg_we,
  input  logic [DW-1:0]    i_delay,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [DW-1:0]    o_delay,
  output logic [DW-1:0]    o_count
);

  logic [DW-1:0] delay_q, delay_d;
  logic [DW-1:0] count_q, count_d;

  // Element 0 is the line input, element i+1 is the output of stage i.
  logic [DEPTH:0]   chain_valid;
  logic [WIDTH-1:0] chain_data [DEPTH+1];

  logic             clr;
  logic             tap_valid;
  logic [WIDTH-1:0] tap_data;

  assign clr            = i_flush | i_cfg_we;
  assign chain_valid[0] = i_valid;
  assign chain_data[0]  = i_data;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    dff_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk_i  (CLK),
      .rst_i  (RST),
      .en_i   (i_en),
      .clr_i  (clr),
      .valid_i(chain_valid[i]),
      .data_i (chain_data[i]),
      .valid_o(chain_valid[i+1]),
      .data_o (chain_data[i+1])
    );
  end

  always_comb begin
    tap_valid = 1'b0;
    tap_data  = '0;
    for (int unsigned i = 1; i <= DEPTH; i++) begin
      if (delay_q == DW'(i)) begin
        tap_valid = chain_valid[i];
        tap_data  = chain_data[i];
      end
    end
  end

  always_comb begin
    delay_d = delay_q;
    count_d = count_q;
    if (i_cfg_we) begin
      delay_d = DW'(clamp_delay(32'(i_delay), DEPTH));
    end
    if (clr) begin
      count_d = '0;
    end else if (i_en) begin
      // Sample entering stage 0 vs. sample leaving the tap on the same edge.
      count_d = count_q + DW'(i_valid) - DW'(tap_valid);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      delay_q <= DW'(DEPTH);
      count_q <= '0;
    end else begin
      delay_q <= delay_d;
      count_q <= count_d;
    end
  end

  assign o_valid = tap_valid;
  assign o_data  = tap_valid ? tap_data : '0;
  assign o_delay = delay_q;
  assign o_count = count_q;

endmodule
